// File: rtl/programm_lader.sv
// ---------------------------------------------------------------------------
// programm_lader
//   Boot loader: reads a length-prefixed program image from the SD card
//   reader and writes it word by word into CPU RAM. The CPU is released
//   from reset only after a complete, successful load.
//
//   Image layout on SD: word QUELL_BASIS holds N (length in words), words
//   QUELL_BASIS+1 .. QUELL_BASIS+N hold the program. They are written to
//   RAM addresses ZIEL_BASIS .. ZIEL_BASIS+N-1.
//
// Ports
//   Clock         in   system clock
//   Reset         in   asynchronous, active-high reset
//   Start         in   one-cycle pulse; (re)starts a load from IDLE/FERTIG/FEHLER
//   SDBusy        in   SD reader busy
//   SDDaten       in   SD read data, valid in the first non-busy cycle
//   SDLesen       out  one-cycle SD read request
//   SDAdresse     out  SD word address, stable through the request
//   RAMSchreiben  out  one-cycle RAM write enable
//   RAMAdresse    out  RAM write address
//   RAMDaten      out  RAM write data
//   CPUReset      out  holds the CPU in reset
//   Fertig        out  load finished successfully
//   Fehler        out  0 = none, 1 = SD timeout, 2 = image too large
//   GeladeneWorte out  number of words written so far
// ---------------------------------------------------------------------------
module programm_lader #(
    parameter int DATEN_BREITE   = 32,
    parameter int SD_ADR_BREITE  = 32,
    parameter int RAM_ADR_BREITE = 16,
    parameter int QUELL_BASIS    = 0,
    parameter int ZIEL_BASIS     = 0,
    parameter int RAM_WORTE      = 1024,
    parameter int TIMEOUT        = 65535,
    parameter bit AUTOSTART      = 1'b1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      SDBusy,
    input  logic [DATEN_BREITE-1:0]   SDDaten,
    output logic                      SDLesen,
    output logic [SD_ADR_BREITE-1:0]  SDAdresse,
    output logic                      RAMSchreiben,
    output logic [RAM_ADR_BREITE-1:0] RAMAdresse,
    output logic [DATEN_BREITE-1:0]   RAMDaten,
    output logic                      CPUReset,
    output logic                      Fertig,
    output logic [1:0]                Fehler,
    output logic [RAM_ADR_BREITE:0]   GeladeneWorte
);

    // The timer counts 0 .. TIMEOUT-1 inside one waiting state.
    localparam int                TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]     TIMER_MAX   = TW'(TIMEOUT - 1);
    // Largest image that fits between ZIEL_BASIS and the end of RAM.
    localparam longint unsigned   PLATZ       = longint'(RAM_WORTE - ZIEL_BASIS);

    // *_ANF issues the one-cycle request, *_WARTEN waits for busy to rise and fall.
    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_WARTEN,
        S_KOPF_ANF,
        S_KOPF_WARTEN,
        S_DATEN_ANF,
        S_DATEN_WARTEN,
        S_SCHREIBEN,
        S_FERTIG,
        S_FEHLER
    } zustand_t;

    zustand_t                  r_zustand;
    zustand_t                  w_naechster;
    logic [TW-1:0]             r_timer;
    logic                      r_busy_gesehen;
    logic [SD_ADR_BREITE-1:0]  r_sd_adresse;
    logic [RAM_ADR_BREITE-1:0] r_ram_adresse;
    logic [DATEN_BREITE-1:0]   r_ram_daten;
    logic [RAM_ADR_BREITE:0]   r_geladen;
    logic [RAM_ADR_BREITE:0]   r_n;
    logic [RAM_ADR_BREITE:0]   w_geladen_neu;
    logic [1:0]                r_fehler;
    logic [1:0]                w_fehler_code;
    logic                      w_sd_fertig;
    logic                      w_timeout;
    logic                      w_n_null;
    logic                      w_n_zu_gross;
    logic                      w_start_ladung;

    // A read completes on the first idle cycle after busy was seen high.
    assign w_sd_fertig    = r_busy_gesehen && !SDBusy;
    assign w_timeout      = (r_timer == TIMER_MAX);
    assign w_n_null       = (SDDaten == '0);
    assign w_n_zu_gross   = (64'(SDDaten) > PLATZ);
    assign w_geladen_neu  = r_geladen + 1'b1;
    assign w_start_ladung = (w_naechster == S_INIT_WARTEN) && (r_zustand != S_INIT_WARTEN);
    // Only a completed header read can lead to the size error.
    assign w_fehler_code  = ((r_zustand == S_KOPF_WARTEN) && w_sd_fertig) ? 2'd2 : 2'd1;

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_zustand <= S_IDLE;
        else       r_zustand <= w_naechster;
    end

    // NOTE: the default assignment first keeps this block free of latches
    // on every path through the case statement.
    always_comb begin
        w_naechster = r_zustand;
        unique case (r_zustand)
            S_IDLE:         if (AUTOSTART || Start) w_naechster = S_INIT_WARTEN;
            S_INIT_WARTEN:  if (!SDBusy)            w_naechster = S_KOPF_ANF;
                            else if (w_timeout)     w_naechster = S_FEHLER;
            S_KOPF_ANF:     if (!SDBusy)            w_naechster = S_KOPF_WARTEN;
                            else if (w_timeout)     w_naechster = S_FEHLER;
            S_KOPF_WARTEN: begin
                if (w_sd_fertig) begin
                    if (w_n_null)          w_naechster = S_FERTIG;
                    else if (w_n_zu_gross) w_naechster = S_FEHLER;
                    else                   w_naechster = S_DATEN_ANF;
                end else if (w_timeout) begin
                    w_naechster = S_FEHLER;
                end
            end
            S_DATEN_ANF:    if (!SDBusy)            w_naechster = S_DATEN_WARTEN;
                            else if (w_timeout)     w_naechster = S_FEHLER;
            S_DATEN_WARTEN: if (w_sd_fertig)        w_naechster = S_SCHREIBEN;
                            else if (w_timeout)     w_naechster = S_FEHLER;
            S_SCHREIBEN:    w_naechster = (w_geladen_neu == r_n) ? S_FERTIG : S_DATEN_ANF;
            S_FERTIG,
            S_FEHLER:       if (Start)              w_naechster = S_INIT_WARTEN;
            default:        w_naechster = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_timer        <= '0;
            r_busy_gesehen <= 1'b0;
            r_sd_adresse   <= '0;
            r_ram_adresse  <= '0;
            r_ram_daten    <= '0;
            r_geladen      <= '0;
            r_n            <= '0;
            r_fehler       <= 2'd0;
        end else begin
            // Every state change restarts the wait budget, so each request
            // and the init wait get their own TIMEOUT cycles.
            r_timer <= (w_naechster != r_zustand) ? '0 : r_timer + 1'b1;

            if (w_start_ladung) begin
                r_geladen <= '0;
                r_fehler  <= 2'd0;
            end
            if ((w_naechster == S_FEHLER) && (r_zustand != S_FEHLER))
                r_fehler <= w_fehler_code;

            case (r_zustand)
                S_INIT_WARTEN:
                    if (!SDBusy) r_sd_adresse <= SD_ADR_BREITE'(QUELL_BASIS);
                S_KOPF_ANF, S_DATEN_ANF:
                    r_busy_gesehen <= 1'b0;
                S_KOPF_WARTEN: begin
                    if (SDBusy) r_busy_gesehen <= 1'b1;
                    if (w_sd_fertig) r_n <= (RAM_ADR_BREITE+1)'(SDDaten);
                    if (w_sd_fertig && (w_naechster == S_DATEN_ANF)) begin
                        r_sd_adresse  <= SD_ADR_BREITE'(QUELL_BASIS + 1);
                        r_ram_adresse <= RAM_ADR_BREITE'(ZIEL_BASIS);
                    end
                end
                S_DATEN_WARTEN: begin
                    if (SDBusy)      r_busy_gesehen <= 1'b1;
                    if (w_sd_fertig) r_ram_daten    <= SDDaten;
                end
                S_SCHREIBEN: begin
                    r_geladen     <= w_geladen_neu;
                    r_ram_adresse <= r_ram_adresse + 1'b1;
                    r_sd_adresse  <= r_sd_adresse + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from the state, so a reset removes them at once.
    assign SDLesen       = ((r_zustand == S_KOPF_ANF) || (r_zustand == S_DATEN_ANF)) && !SDBusy;
    assign RAMSchreiben  = (r_zustand == S_SCHREIBEN);
    assign Fertig        = (r_zustand == S_FERTIG);
    assign CPUReset      = (r_zustand != S_FERTIG);
    assign SDAdresse     = r_sd_adresse;
    assign RAMAdresse    = r_ram_adresse;
    assign RAMDaten      = r_ram_daten;
    assign Fehler        = r_fehler;
    assign GeladeneWorte = r_geladen;

endmodule

// File: tb/tb_programm_lader.sv
// Bench for programm_lader. Two instances with their own SD reader models:
//   index 0: AUTOSTART=1, ZIEL_BASIS=1000, RAM_WORTE=1024, TIMEOUT=100
//   index 1: AUTOSTART=0, ZIEL_BASIS=0,    RAM_WORTE=1024, TIMEOUT=100
// Expected RAM writes come from the image placed in the SD model memory.
module tb_programm_lader;

    typedef struct packed {
        logic [15:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        int         n;
        int         lat;
        logic [1:0] exp_fehler;
        logic       exp_fertig;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        start    [2];
    logic        sd_busy  [2];
    logic [31:0] sd_daten [2] = '{32'd0, 32'd0};
    logic        sd_lesen [2];
    logic [31:0] sd_adr   [2];
    logic        ram_we   [2];
    logic [15:0] ram_adr  [2];
    logic [31:0] ram_dat  [2];
    logic        cpu_rst  [2];
    logic        fertig   [2];
    logic [1:0]  fehler   [2];
    logic [16:0] geladen  [2];

    // SD model state
    logic [31:0] sd_mem  [2][0:63];
    int          sd_lat  [2];
    int          hang_ab [2];
    int          mcnt    [2] = '{0, 0};
    logic [31:0] madr    [2] = '{32'd0, 32'd0};
    int          nreq    [2] = '{0, 0};
    int          req_cyc [2][0:1023];
    int          cyc = 0;

    // Write monitor
    wr_t         wlog [2][0:1023];
    int          wcnt [2] = '{0, 0};
    int          ovl  [2] = '{0, 0};

    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tab [6];

    always #5 clk = ~clk;

    programm_lader #(
        .ZIEL_BASIS(1000), .RAM_WORTE(1024), .TIMEOUT(100), .AUTOSTART(1'b1)
    ) u_dut0 (
        .Clock(clk), .Reset(rst[0]), .Start(start[0]), .SDBusy(sd_busy[0]),
        .SDDaten(sd_daten[0]), .SDLesen(sd_lesen[0]), .SDAdresse(sd_adr[0]),
        .RAMSchreiben(ram_we[0]), .RAMAdresse(ram_adr[0]), .RAMDaten(ram_dat[0]),
        .CPUReset(cpu_rst[0]), .Fertig(fertig[0]), .Fehler(fehler[0]),
        .GeladeneWorte(geladen[0])
    );

    programm_lader #(
        .ZIEL_BASIS(0), .RAM_WORTE(1024), .TIMEOUT(100), .AUTOSTART(1'b0)
    ) u_dut1 (
        .Clock(clk), .Reset(rst[1]), .Start(start[1]), .SDBusy(sd_busy[1]),
        .SDDaten(sd_daten[1]), .SDLesen(sd_lesen[1]), .SDAdresse(sd_adr[1]),
        .RAMSchreiben(ram_we[1]), .RAMAdresse(ram_adr[1]), .RAMDaten(ram_dat[1]),
        .CPUReset(cpu_rst[1]), .Fertig(fertig[1]), .Fehler(fehler[1]),
        .GeladeneWorte(geladen[1])
    );

    // SD reader model: busy for 4 cycles after reset (initialisation), then
    // each request raises busy for sd_lat cycles; data appears as busy falls.
    // The request numbered hang_ab is swallowed (busy never rises).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                sd_busy[g] <= 1'b1;
                mcnt[g]    <= 3;
            end else if (sd_lesen[g]) begin
                req_cyc[g][nreq[g] % 1024] <= cyc;
                nreq[g] <= nreq[g] + 1;
                if (nreq[g] + 1 != hang_ab[g]) begin
                    sd_busy[g] <= 1'b1;
                    mcnt[g]    <= sd_lat[g] - 1;
                    madr[g]    <= sd_adr[g];
                end
            end else if (sd_busy[g]) begin
                if (mcnt[g] == 0) begin
                    sd_busy[g]  <= 1'b0;
                    sd_daten[g] <= sd_mem[g][madr[g][5:0]];
                end else begin
                    mcnt[g] <= mcnt[g] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ram_we[g]) begin
                wlog[g][wcnt[g] % 1024] <= {ram_adr[g], ram_dat[g]};
                wcnt[g] <= wcnt[g] + 1;
            end
            if (ram_we[g] && sd_lesen[g]) ovl[g] <= ovl[g] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(string tag, int g);
        check({tag, "_strobes"}, 64'({sd_lesen[g], ram_we[g]}), 64'(0));
        check({tag, "_flags"},   64'({cpu_rst[g], fertig[g], fehler[g]}), 64'(4'b1000));
        check({tag, "_adr"},     64'({sd_adr[g], ram_adr[g]}), 64'(0));
        check({tag, "_dat"},     64'(ram_dat[g]), 64'(0));
        check({tag, "_geladen"}, 64'(geladen[g]), 64'(0));
    endtask

    task automatic wait_done(int g, int budget, output int done_cyc);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = fertig[g] || (fehler[g] != 2'd0);
        end
        done_cyc = cyc;
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done[%0d]: no Fertig/Fehler within %0d cycles", g, budget);
        end
        #1;
    endtask

    task automatic pulse_start(int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic fill_image(int g, int n, int seed);
        sd_mem[g][0] = 32'(n);
        for (int k = 0; k < n && k < 63; k++) sd_mem[g][1 + k] = 32'(32'hA + k + seed);
    endtask

    // Reset-driven (re)load of instance 0; returns the write-log start index.
    task automatic lade0(int lat, int hang_nach, output int base);
        rst[0]     = 1'b1;
        sd_lat[0]  = lat;
        hang_ab[0] = (hang_nach == 0) ? 0 : nreq[0] + hang_nach;
        repeat (2) @(negedge clk);
        #1;
        base   = wcnt[0];
        rst[0] = 1'b0;
    endtask

    task automatic verify(string tag, int g, int n, int ziel, int base,
                          logic [1:0] exp_feh, logic exp_fer);
        int  exp_w;
        wr_t w;
        exp_w = exp_fer ? n : 0;
        check({tag, "_fertig"},  64'(fertig[g]),  64'(exp_fer));
        check({tag, "_fehler"},  64'(fehler[g]),  64'(exp_feh));
        check({tag, "_cpurst"},  64'(cpu_rst[g]), 64'(!exp_fer));
        check({tag, "_geladen"}, 64'(geladen[g]), 64'(exp_w));
        check({tag, "_nwrites"}, 64'(wcnt[g] - base), 64'(exp_w));
        for (int k = 0; k < exp_w; k++) begin
            w = wlog[g][(base + k) % 1024];
            check({tag, "_write"}, 64'({w.adr, w.dat}), 64'({16'(ziel + k), sd_mem[g][1 + k]}));
        end
    endtask

    initial begin
        int  base;
        int  dc;
        int  q0;
        int  n;
        bit  hit;
        logic [1:0] exp_feh;
        logic [1:0] prev_feh;

        rst     = '{1'b1, 1'b1};
        start   = '{1'b0, 1'b0};
        sd_lat  = '{3, 3};
        hang_ab = '{0, 0};
        #1;
        chk_reset("rst0", 0);
        chk_reset("rst1", 1);

        // ---- table-driven loads on instance 0 (ZIEL_BASIS=1000) ----
        tab[0] = '{3,  5, 2'd0, 1'b1};
        tab[1] = '{0,  5, 2'd0, 1'b1};
        tab[2] = '{25, 2, 2'd2, 1'b0};
        tab[3] = '{24, 1, 2'd0, 1'b1};
        tab[4] = '{1,  1, 2'd0, 1'b1};
        tab[5] = '{2,  3, 2'd0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            fill_image(0, tab[i].n, i * 32'h100);
            lade0(tab[i].lat, 0, base);
            wait_done(0, 3000, dc);
            verify($sformatf("vec%0d", i), 0, tab[i].n, 1000, base,
                   tab[i].exp_fehler, tab[i].exp_fertig);
            if (tab[i].n == 24)
                check("last_adr", 64'(wlog[0][(base + 23) % 1024].adr), 64'(1023));
        end

        // ---- timeout: second data request is never answered ----
        fill_image(0, 4, 32'h500);
        lade0(2, 3, base);
        wait_done(0, 1000, dc);
        check("to_fehler",  64'(fehler[0]),  64'(1));
        check("to_geladen", 64'(geladen[0]), 64'(1));
        check("to_cpurst",  64'({cpu_rst[0], fertig[0]}), 64'(2'b10));
        check("to_delta_ok", 64'((dc - req_cyc[0][(hang_ab[0] - 1) % 1024]) inside {[100:101]}), 64'(1));
        check("to_nwrites", 64'(wcnt[0] - base), 64'(1));
        hang_ab[0] = 0;

        // ---- reset in the middle of an N=4 load ----
        fill_image(0, 4, 32'h600);
        lade0(3, 0, base);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            hit = (geladen[0] == 17'd1);
        end
        check("mid_reached", 64'(hit), 64'(1));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst[0] = 1'b1;
        #1;
        chk_reset("mid_rst", 0);
        base = wcnt[0];
        repeat (3) @(negedge clk);
        #1;
        check("mid_no_we", 64'(wcnt[0] - base), 64'(0));
        q0     = nreq[0];
        rst[0] = 1'b0;
        wait_done(0, 1000, dc);
        verify("mid_reload", 0, 4, 1000, base, 2'd0, 1'b1);
        check("mid_requests", 64'(nreq[0] - q0), 64'(5));

        // ---- instance 1: AUTOSTART=0 waits for Start ----
        fill_image(1, 3, 0);
        sd_lat[1] = 5;
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("as0_no_req", 64'(nreq[1]), 64'(0));
        check("as0_held",   64'({cpu_rst[1], fertig[1]}), 64'(2'b10));
        base = wcnt[1];
        pulse_start(1);
        wait_done(1, 1000, dc);
        verify("as0_load", 1, 3, 0, base, 2'd0, 1'b1);

        // Reload a changed image; a Start pulse during the load is ignored.
        sd_mem[1][0] = 32'd2;
        sd_mem[1][1] = 32'h11;
        sd_mem[1][2] = 32'h22;
        base = wcnt[1];
        pulse_start(1);
        check("reload_restart", 64'({cpu_rst[1], fertig[1], geladen[1]}), 64'({2'b10, 17'd0}));
        repeat (4) @(negedge clk);
        pulse_start(1);
        wait_done(1, 1000, dc);
        verify("reload", 1, 2, 0, base, 2'd0, 1'b1);

        // ---- randomized loads on instance 1 against the image model ----
        prev_feh = 2'd0;
        for (int it = 0; it < 12; it++) begin
            n = ($urandom_range(0, 4) == 0) ? 1025 + int'($urandom_range(0, 100))
                                             : int'($urandom_range(0, 10));
            sd_mem[1][0] = 32'(n);
            for (int k = 0; k < 10; k++) sd_mem[1][1 + k] = $urandom;
            sd_lat[1] = int'($urandom_range(1, 5));
            exp_feh   = (n > 1024) ? 2'd2 : 2'd0;
            base      = wcnt[1];
            pulse_start(1);
            if (prev_feh != 2'd0) check("rnd_fehler_clr", 64'(fehler[1]), 64'(0));
            wait_done(1, 2000, dc);
            verify($sformatf("rnd%0d", it), 1, n, 0, base, exp_feh, exp_feh == 2'd0);
            prev_feh = exp_feh;
        end

        check("no_overlap", 64'(ovl[0] + ovl[1]), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
